// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the M-stage CPU port and a burst loader/debug port.
// Define ARB_FAIRNESS_EN to force the loader in after STARVE_LIMIT consecutive lost arbitrations.
module dmem_arbiter #(
   parameter int AW = 21,
   parameter int DW = 32,
   parameter int MAX_BURST = 16,
   parameter int STARVE_LIMIT = 8
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cpu_req,
   input  logic                        cpu_we,
   input  logic [AW-1:0]               cpu_addr,
   input  logic [DW-1:0]               cpu_wdata,
   output logic [DW-1:0]               cpu_rdata,
   output logic                        cpu_stall,
   input  logic                        ldr_req,
   input  logic                        ldr_we,
   input  logic [AW-1:0]               ldr_addr,
   input  logic [$clog2(MAX_BURST):0]  ldr_len,
   input  logic [DW-1:0]               ldr_wdata,
   output logic                        ldr_ack,
   output logic [DW-1:0]               ldr_rdata,
   output logic                        ldr_done,
   output logic                        busy,
   output logic                        mem_we,
   output logic [AW-1:0]               mem_addr,
   output logic [DW-1:0]               mem_wdata,
   input  logic [DW-1:0]               mem_rdata
);
   localparam int LW = $clog2(MAX_BURST) + 1;
   typedef enum logic {IDLE, LBURST} state_t;
   state_t state;
   logic [LW-1:0] remaining, len_eff;
   logic [AW-1:0] addr_ptr;
   logic dir, force_ldr, cpu_gnt, ldr_gnt, beat;
   always_comb begin
      len_eff = ldr_len == '0 ? LW'(1) : ldr_len > LW'(MAX_BURST) ? LW'(MAX_BURST) : ldr_len;
      cpu_gnt = reset && state == IDLE && cpu_req && !force_ldr;
      ldr_gnt = reset && state == IDLE && ldr_req && !cpu_gnt;
      beat    = reset && state == LBURST && ldr_req;
   end
`ifdef ARB_FAIRNESS_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve;
   assign force_ldr = starve == SW'(STARVE_LIMIT);
   always_ff @(posedge clk or negedge reset)
      if (!reset) starve <= '0;
      else if (ldr_gnt || !ldr_req) starve <= '0;
      else if (cpu_gnt) starve <= starve + 1'b1;
`else
   assign force_ldr = 1'b0;
`endif
   // every output is gated by reset so the memory sees no traffic while reset is low
   assign mem_we    = cpu_gnt ? cpu_we : ldr_gnt ? ldr_we : beat && dir;
   assign mem_addr  = cpu_gnt ? cpu_addr : ldr_gnt ? ldr_addr : beat ? addr_ptr : '0;
   assign mem_wdata = cpu_gnt ? cpu_wdata : (ldr_gnt || beat) ? ldr_wdata : '0;
   assign ldr_ack   = ldr_gnt || beat;
   assign cpu_stall = reset && cpu_req && !cpu_gnt;
   assign cpu_rdata = reset ? mem_rdata : '0;
   assign ldr_rdata = reset ? mem_rdata : '0;
   assign busy      = state == LBURST;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state     <= IDLE;
         remaining <= '0;
         addr_ptr  <= '0;
         dir       <= 1'b0;
         ldr_done  <= 1'b0;
      end else begin
         ldr_done <= (ldr_gnt && len_eff == LW'(1)) || (beat && remaining == LW'(1));
         if (ldr_gnt && len_eff != LW'(1)) begin
            state     <= LBURST;
            remaining <= len_eff - 1'b1;
            addr_ptr  <= ldr_addr + 1'b1;
            dir       <= ldr_we;
         end else if (state == LBURST) begin
            if (!ldr_req || remaining == LW'(1)) state <= IDLE;
            if (beat) begin
               addr_ptr  <= addr_ptr + 1'b1;
               remaining <= remaining - 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized + directed scoreboard bench for dmem_arbiter against a cycle-level reference model.
module tb_dmem_arbiter;
   localparam int AW = 21, DW = 32, MB = 16, SL = 8;
`ifdef ARB_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0, ldr_addr = '0, mem_addr;
   logic [DW-1:0] cpu_wdata = '0, ldr_wdata = '0, cpu_rdata, ldr_rdata, mem_wdata, mem_rdata;
   logic [4:0] ldr_len = '0;
   logic cpu_stall, ldr_ack, ldr_done, busy, mem_we;
   dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .ldr_req(ldr_req),
      .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_len(ldr_len), .ldr_wdata(ldr_wdata),
      .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata), .ldr_done(ldr_done), .busy(busy),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));
   logic [DW-1:0] mem [1024];
   assign mem_rdata = mem[mem_addr[9:0]];
   always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
   typedef struct {
      bit ack, stall, we, done, busy, crv, lrv;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata, crd, lrd;
   } exp_t;
   exp_t q[$];
   int checks = 0, errors = 0;
   bit mon_on = 1'b0;
   logic [DW-1:0] rmem [1024];
   bit rknown [1024];
   bit in_b = 1'b0, bdir = 1'b0, dpend = 1'b0;
   int left = 0, nptr = 0, starve = 0;
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", n, act, want, $time);
      end
   endtask
   task automatic acc(input bit w, input int a, input logic [DW-1:0] d, output bit v, output logic [DW-1:0] rd);
      v = 1'b0;
      rd = '0;
      if (w) begin
         rmem[a % 1024] = d;
         rknown[a % 1024] = 1'b1;
      end else if (rknown[a % 1024]) begin
         v = 1'b1;
         rd = rmem[a % 1024];
      end
   endtask
   // reference: expected outputs for this cycle from the current inputs, then advance the model
   task automatic model();
      exp_t e;
      bit cg, lg;
      int len;
      e = '{default: '0};
      if (!reset) begin
         in_b = 1'b0; dpend = 1'b0; starve = 0;
         e.crv = 1'b1; e.lrv = 1'b1;
      end else begin
         e.done = dpend;
         dpend = 1'b0;
         e.busy = in_b;
         if (in_b) begin
            e.stall = cpu_req;
            if (ldr_req) begin
               e.ack = 1'b1; e.we = bdir; e.addr = AW'(nptr); e.wdata = ldr_wdata;
               acc(bdir, nptr, ldr_wdata, e.lrv, e.lrd);
               nptr = (nptr + 1) % (1 << AW);
               left--;
               if (left == 0) begin in_b = 1'b0; dpend = 1'b1; end
            end else in_b = 1'b0;
         end else begin
            cg = cpu_req && !(FAIR && starve == SL);
            lg = ldr_req && !cg;
            e.stall = cpu_req && !cg;
            if (cg) begin
               e.we = cpu_we; e.addr = cpu_addr; e.wdata = cpu_wdata;
               acc(cpu_we, int'(cpu_addr), cpu_wdata, e.crv, e.crd);
               if (ldr_req) starve++;
            end
            if (lg) begin
               len = ldr_len == 0 ? 1 : ldr_len > MB ? MB : int'(ldr_len);
               e.ack = 1'b1; e.we = ldr_we; e.addr = ldr_addr; e.wdata = ldr_wdata;
               acc(ldr_we, int'(ldr_addr), ldr_wdata, e.lrv, e.lrd);
               starve = 0;
               if (len == 1) dpend = 1'b1;
               else begin
                  in_b = 1'b1; left = len - 1; bdir = ldr_we;
                  nptr = (int'(ldr_addr) + 1) % (1 << AW);
               end
            end
         end
         if (!ldr_req) starve = 0;
      end
      q.push_back(e);
   endtask
   task automatic drive(input bit r, cq, cw, input int ca, input logic [DW-1:0] cd,
                        input bit lq, lw, input int la, input int ll, input logic [DW-1:0] ld);
      @(posedge clk);
      #1;
      reset = r; cpu_req = cq; cpu_we = cw; cpu_addr = AW'(ca); cpu_wdata = cd;
      ldr_req = lq; ldr_we = lw; ldr_addr = AW'(la); ldr_len = 5'(ll); ldr_wdata = ld;
      model();
      mon_on = 1'b1;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   exp_t m;
   always @(negedge clk) if (mon_on) begin
      if (q.size() == 0) begin
         checks++; errors++;
         $display("FAIL queue_empty got 0 entries want 1 at %0t", $time);
      end else begin
         m = q.pop_front();
         chk("ldr_ack", ldr_ack, m.ack);
         chk("cpu_stall", cpu_stall, m.stall);
         chk("mem_we", mem_we, m.we);
         chk("mem_addr", mem_addr, m.addr);
         chk("mem_wdata", mem_wdata, m.wdata);
         chk("ldr_done", ldr_done, m.done);
         chk("busy", busy, m.busy);
         if (m.crv) chk("cpu_rdata", cpu_rdata, m.crd);
         if (m.lrv) chk("ldr_rdata", ldr_rdata, m.lrd);
      end
   end
   bit lq;
   initial begin
      for (int i = 0; i < 3; i++) drive(0, 1, 1, 5, 32'h1234, 1, 1, 9, 3, 32'h99);
      idle(1);
      drive(1, 1, 1, 28, 10, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 28, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 1, 1, 'h100, 4, 32'hA + i);
      idle(1);
      drive(1, 0, 0, 0, 0, 1, 1, 'h200, 0, 32'h55);
      idle(1);
      drive(1, 0, 0, 0, 0, 1, 1, 'h1FFFFF, 2, 32'h66);
      drive(1, 0, 0, 0, 0, 1, 1, 'h1FFFFF, 2, 32'h77);
      idle(1);
      for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 1, 0, 'h100, 4, 0);
      idle(1);
      for (int i = 0; i < 2; i++) drive(1, 1, 0, 28, 0, 1, 1, 'h300, 4, 1);
      drive(1, 0, 0, 0, 0, 1, 1, 'h300, 4, 1);
      drive(1, 0, 0, 0, 0, 1, 1, 'h300, 4, 2);
      drive(1, 1, 0, 28, 0, 1, 1, 'h300, 4, 3);
      drive(1, 1, 0, 28, 0, 1, 1, 'h300, 4, 4);
      drive(1, 1, 0, 'h300, 0, 0, 0, 0, 0, 0);
      idle(1);
      drive(1, 0, 0, 0, 0, 1, 1, 'h400, 8, 7);
      drive(1, 0, 0, 0, 0, 1, 1, 'h400, 8, 8);
      idle(2);
      for (int i = 0; i < 100; i++) drive(1, 1, 1, 'h40, i, 1, 1, 'h500, 1, 32'hF0 + i);
      idle(1);
      for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 1, 1, 'h600, 8, 32'h60 + i);
      drive(0, 0, 0, 0, 0, 1, 1, 'h600, 8, 32'h63);
      drive(0, 0, 0, 0, 0, 1, 1, 'h600, 8, 32'h64);
      idle(3);
      lq = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         lq = lq ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 4) == 0);
         drive($urandom_range(0, 199) != 0, $urandom_range(0, 2) == 0, 1'($urandom),
               $urandom_range(0, 1023), $urandom, lq, 1'($urandom),
               $urandom_range(0, 3) == 0 ? 'h1FFFF0 + $urandom_range(0, 15) : $urandom_range(0, 1023),
               $urandom_range(0, 31), $urandom);
      end
      @(negedge clk);
      #1;
      mon_on = 1'b0;
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and burst sequencer for the single-port data memory. It shares the memory between the pipeline's Memory stage (CPU port) and a loader/debug port that preloads or dumps memory in bursts. It sits between the datapath's M stage and the data memory. It drives a stall request into the hazard unit while the CPU is locked out.

## Interface

Parameters:
- AW, 21: word-address width (2M-word memory).
- DW, 32: data width.
- MAX_BURST, 16: maximum loader burst length in beats.
- STARVE_LIMIT, 8: consecutive lost arbitrations before the loader is forced in (see Configuration).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  M-stage memory access request.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  AW  CPU word address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  read data to M stage (mem_rdata passthrough).
- cpu_stall  out  1  to hazard unit; asserted when cpu_req=1 and the CPU is not granted.
- ldr_req  in  1  loader request; held for the whole burst.
- ldr_we  in  1  loader direction, sampled at the first beat only.
- ldr_addr  in  AW  burst base address, sampled at the first beat.
- ldr_len  in  $clog2(MAX_BURST)+1  burst length, sampled at the first beat.
- ldr_wdata  in  DW  write data, one word per acked beat.
- ldr_ack  out  1  a beat is performed this cycle.
- ldr_rdata  out  DW  read data for the current beat (mem_rdata passthrough).
- ldr_done  out  1  one-cycle pulse, registered, after the final beat.
- busy  out  1  FSM in LBURST.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory word address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, combinational from mem_addr.

## Operation

- FSM states:
  - IDLE: arbitrate each cycle.
  - LBURST: loader owns the memory.
- IDLE arbitration:
  - If cpu_req=1, the CPU is granted: mem_* = cpu_*.
  - Otherwise, if ldr_req=1, the loader is granted and beat 0 executes this cycle:
    - Latch base = ldr_addr, dir = ldr_we.
    - Effective length L = ldr_len, with 0 treated as 1 and values above MAX_BURST clamped to MAX_BURST.
    - If L>1, go to LBURST with remaining = L-1 and addr_ptr = base+1.
    - If L=1, set ldr_done next cycle.
  - With no request: mem_we=0, mem_addr=0, mem_wdata=0.
- LBURST:
  - Each cycle with ldr_req=1 is a beat: mem_addr = addr_ptr, mem_we = dir, mem_wdata = ldr_wdata, ldr_ack=1.
  - On each beat, addr_ptr increments modulo 2^AW (wraps 2^AW-1 → 0) and remaining decrements.
  - On the beat with remaining=1, go to IDLE and set ldr_done for the next cycle.
  - If ldr_req=0 in LBURST, the burst aborts: no access this cycle, go to IDLE, no ldr_done.
  - cpu_stall = cpu_req for every LBURST cycle.
- cpu_we/ldr_we only reach mem_we on a cycle where that port is granted.
- While reset is low: state=IDLE, remaining=0, addr_ptr=0, starve=0, ldr_done=0. All outputs are forced to 0, including mem_we.
- Reset asserted mid-burst: the burst is discarded, no ldr_done. The loader must reissue.

## Timing

- CPU access has zero added latency: granted in the request cycle, write committed at that clock edge, read data valid the same cycle.
- A loader burst of L beats with no CPU contention occupies L consecutive cycles.
  - ldr_done is high in cycle L+1 (counting the first beat as cycle 1).
  - The CPU may be granted in that same cycle.
- CPU arriving mid-burst waits exactly the remaining beats. cpu_stall drops in the cycle the FSM returns to IDLE.
- Simultaneous cpu_req and ldr_req in IDLE: the CPU wins, subject to the fairness override below.
- Reset values:
  - cpu_stall=0, ldr_ack=0, ldr_done=0, busy=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_rdata=0, ldr_rdata=0.

## Configuration

- ARB_FAIRNESS_EN defined:
  - A starve counter increments on each IDLE cycle where ldr_req=1 and the CPU is granted.
  - When starve==STARVE_LIMIT, the next IDLE cycle grants the loader despite cpu_req, with cpu_stall=1.
  - The counter clears on any loader grant, or when ldr_req=0.
- ARB_FAIRNESS_EN undefined: strict CPU priority; the loader can starve indefinitely. The counter is not built.

## Test plan

- Reset: start a len=8 write burst, pull reset low after beat 3 → all outputs 0 immediately; after release, busy=0 and no ldr_done pulse.
- CPU only: cpu_req=1, we=1, addr=28, wdata=10 → mem_we=1, mem_addr=28, cpu_stall=0 same cycle; next cycle a read of 28 gives cpu_rdata=10.
- Loader write: base 0x100, len=4, data 0xA..0xD → mem_addr 0x100..0x103 on 4 consecutive acked cycles, ldr_done in cycle 5; len=0 → one beat; base 0x1FFFFF, len=2 → addresses 0x1FFFFF, 0x000000.
- Contention: both request in IDLE → CPU granted, ldr_ack=0. Drop cpu_req → burst len=4 starts. Raise cpu_req at beat 2 → cpu_stall=1 for 2 cycles, CPU granted in the ldr_done cycle.
- Abort: len=8, drop ldr_req after beat 2 → no access that cycle, IDLE next, ldr_done never pulses.
- Fairness: cpu_req and ldr_req held continuously, STARVE_LIMIT=8 → with ARB_FAIRNESS_EN the loader is acked on cycle 9; without it, no ldr_ack in 100 cycles.
